// File: rtl/phase_acc_fold.sv
// Phase accumulator with quadrant fold for a first-quadrant cosine LUT stage.
// Optional LFSR phase dither is enabled by defining PHASE_DITHER_EN.
module phase_acc_fold #(
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned OUT_WIDTH = 14
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic [ACC_WIDTH-1:0] iFtw,
  input  logic                 iLoad,
  input  logic [ACC_WIDTH-1:0] iPhase,
  output logic [OUT_WIDTH-1:0] oCx_g,
  output logic [1:0]           oQuad,
  output logic                 oNeg,
  output logic                 oNegAlign,
  output logic                 oValid,
  output logic                 oValidAlign
);

  localparam int unsigned FRAC = ACC_WIDTH - 2 - OUT_WIDTH;
  localparam int unsigned HIW  = ACC_WIDTH - FRAC;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 v1_q;
  logic [OUT_WIDTH-1:0] cx_q, cx_d;
  logic [1:0]           quad_q, quad_d;
  logic                 neg_q, neg_d;
  logic                 val_q, nega_q, vala_q;
  logic [HIW-1:0]       ph;
  logic [OUT_WIDTH-1:0] f;

  always_comb begin
    acc_d = acc_q;
    if (iLoad)
      acc_d = iPhase;
    else if (iEn)
      acc_d = acc_q + iFtw;
  end

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        fb, carry;

  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = v1_q ? {fb, lfsr_q[15:1]} : lfsr_q;
  end

  // Only the carry out of the truncated bits matters: a + d overflows FRAC bits iff a > ~d.
  always_comb begin
    carry = acc_q[FRAC-1:0] > ~lfsr_q[FRAC-1:0];
    ph    = acc_q[ACC_WIDTH-1:FRAC] + HIW'(carry);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  always_comb ph = acc_q[ACC_WIDTH-1:FRAC];
`endif

  always_comb begin
    quad_d = ph[HIW-1 -: 2];
    f      = ph[OUT_WIDTH-1:0];
    cx_d   = quad_d[0] ? ~f : f;
    neg_d  = quad_d[0] ^ quad_d[1];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc_q  <= '0;
      v1_q   <= 1'b0;
      cx_q   <= '0;
      quad_q <= '0;
      neg_q  <= 1'b0;
      val_q  <= 1'b0;
      nega_q <= 1'b0;
      vala_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      v1_q   <= iEn | iLoad;
      cx_q   <= cx_d;
      quad_q <= quad_d;
      neg_q  <= neg_d;
      val_q  <= v1_q;
      nega_q <= neg_q;
      vala_q <= val_q;
    end
  end

  assign oCx_g       = cx_q;
  assign oQuad       = quad_q;
  assign oNeg        = neg_q;
  assign oValid      = val_q;
  assign oNegAlign   = nega_q;
  assign oValidAlign = vala_q;

endmodule

// File: tb/tb_phase_acc_fold.sv
// Randomized and directed bench for phase_acc_fold against an arithmetic phase model.
module tb_phase_acc_fold;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEn = 1'b0, iLoad = 1'b0;
  logic [23:0] iFtw = '0, iPhase = '0;
  logic [13:0] oCx_g;
  logic [1:0]  oQuad;
  logic        oNeg, oNegAlign, oValid, oValidAlign;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned m_acc, m_v1, m_cx, m_q, m_neg, m_val, m_nega, m_vala, m_lfsr;

  phase_acc_fold #(.ACC_WIDTH(24), .OUT_WIDTH(14)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iFtw(iFtw), .iLoad(iLoad), .iPhase(iPhase),
    .oCx_g(oCx_g), .oQuad(oQuad), .oNeg(oNeg), .oNegAlign(oNegAlign),
    .oValid(oValid), .oValidAlign(oValidAlign)
  );

  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_v1 = 0; m_cx = 0; m_q = 0; m_neg = 0;
    m_val = 0; m_nega = 0; m_vala = 0; m_lfsr = 'hACE1;
  endtask

  // One rising edge of the reference: phase -> quadrant/fraction by plain arithmetic.
  task automatic model_edge();
    int unsigned p, f, dith, bit0;
    dith = 0;
`ifdef PHASE_DITHER_EN
    dith = m_lfsr % 256;
`endif
    p      = (m_acc + dith) % 32'h0100_0000;
    m_nega = m_neg;
    m_vala = m_val;
    m_q    = p / 32'h0040_0000;
    f      = (p / 256) % 16384;
    m_cx   = (m_q == 1 || m_q == 3) ? 16383 - f : f;
    m_neg  = (m_q == 1 || m_q == 2) ? 1 : 0;
    m_val  = m_v1;
    if (m_v1 != 0) begin
      bit0   = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (bit0 << 15);
    end
    if (iLoad)    m_acc = iPhase;
    else if (iEn) m_acc = (m_acc + iFtw) % 32'h0100_0000;
    m_v1 = (iEn || iLoad) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".cx"},   oCx_g,       m_cx);
    check_eq({tag, ".quad"}, oQuad,       m_q);
    check_eq({tag, ".neg"},  oNeg,        m_neg);
    check_eq({tag, ".val"},  oValid,      m_val);
    check_eq({tag, ".negA"}, oNegAlign,   m_nega);
    check_eq({tag, ".valA"}, oValidAlign, m_vala);
  endtask

  task automatic step(input string tag);
    @(posedge iClk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic en, input logic ld, input logic [23:0] ftw, input logic [23:0] ph);
    iEn = en; iLoad = ld; iFtw = ftw; iPhase = ph;
  endtask

  initial begin
    int unsigned exp_q[4]  = '{0, 1, 2, 3};
    int unsigned exp_cx[4] = '{'h0000, 'h3FFF, 'h0000, 'h3FFF};
    int unsigned exp_ng[4] = '{0, 1, 1, 0};
    int unsigned neg_prev;

    model_reset();
    #1;
    check_all("reset");
    @(negedge iClk);
    iRst = 1'b0;

`ifndef PHASE_DITHER_EN
    // Quadrant walk from phase 0
    drive(1'b0, 1'b1, 24'h0, 24'h0);
    step("q_load");
    drive(1'b1, 1'b0, 24'h400000, 24'h0);
    for (int i = 0; i < 4; i++) begin
      step("q_walk");
      check_eq("walk_quad", oQuad, exp_q[i]);
      check_eq("walk_cx", oCx_g, exp_cx[i]);
      check_eq("walk_neg", oNeg, exp_ng[i]);
    end

    // Load beats enable
    drive(1'b1, 1'b1, 24'h000100, 24'h123456);
    step("ld_pri");
    drive(1'b0, 1'b0, 24'h000100, 24'h0);
    step("ld_pri2");
    check_eq("ld_pri_cx", oCx_g, 'h1234);
    check_eq("ld_pri_quad", oQuad, 0);

    // Modular wrap
    drive(1'b0, 1'b1, 24'h0, 24'hFFFF00);
    step("wrap_ld");
    drive(1'b1, 1'b0, 24'h000200, 24'h0);
    step("wrap_en");
    drive(1'b0, 1'b0, 24'h0, 24'h0);
    step("wrap_out");
    check_eq("wrap_quad", oQuad, 0);
    check_eq("wrap_cx", oCx_g, 'h0001);
    check_eq("wrap_neg", oNeg, 0);

    // Boundary fold points
    drive(1'b0, 1'b1, 24'h0, 24'h3FFFFF);
    step("b1_ld");
    drive(1'b0, 1'b1, 24'h0, 24'h400000);
    step("b2_ld");
    check_eq("b3fffff_cx", oCx_g, 'h3FFF);
    check_eq("b3fffff_quad", oQuad, 0);
    drive(1'b0, 1'b0, 24'h0, 24'h0);
    step("b_idle");
    check_eq("b400000_cx", oCx_g, 'h3FFF);
    check_eq("b400000_quad", oQuad, 1);
    check_eq("b400000_neg", oNeg, 1);
`endif

    // Single enable pulse and alignment delay
    drive(1'b0, 1'b0, 24'h0, 24'h0);
    for (int i = 0; i < 3; i++) step("pulse_idle");
    drive(1'b1, 1'b0, 24'h5A5A5A, 24'h0);
    step("pulse_n");
    drive(1'b0, 1'b0, 24'h0, 24'h0);
    step("pulse_n1");
    check_eq("pulse_val_n1", oValid, 1);
    check_eq("pulse_valA_n1", oValidAlign, 0);
    neg_prev = m_neg;
    step("pulse_n2");
    check_eq("pulse_val_n2", oValid, 0);
    check_eq("pulse_valA_n2", oValidAlign, 1);
    check_eq("pulse_negA", oNegAlign, neg_prev);
    step("pulse_n3");
    check_eq("pulse_valA_n3", oValidAlign, 0);

    // Zero tuning word keeps output constant while valid
    drive(1'b1, 1'b0, 24'h0, 24'h0);
    for (int i = 0; i < 4; i++) step("ftw0");

    // Randomized stream with a mid-stream asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        @(negedge iClk);
        iRst = 1'b1;
        #1;
        check_eq("arst_val", oValid, 0);
        check_eq("arst_cx", oCx_g, 0);
        check_eq("arst_quad", oQuad, 0);
        check_eq("arst_neg", oNeg, 0);
        check_eq("arst_negA", oNegAlign, 0);
        check_eq("arst_valA", oValidAlign, 0);
        model_reset();
        #1;
        iRst = 1'b0;
      end
      if (i >= 294 && i < 300)
        drive(1'b1, 1'b0, 24'($urandom), 24'($urandom));
      else
        drive(($urandom % 4) != 0, ($urandom % 8) == 0,
              ($urandom % 2) ? 24'($urandom) : 24'($urandom % 4096), 24'($urandom));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/phase_acc_fold.md
PHASE_ACC_FOLD -- requirements
Module: phase_acc_fold

Interface
REQ-001 Parameter ACC_WIDTH, default 24: phase accumulator width in bits; fixed at 24 for this release.
REQ-002 Parameter OUT_WIDTH, default 14: folded phase width; matches the cosine LUT stage input.
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst  input  1  asynchronous, active-high reset.
REQ-005 iEn  input  1  advance accumulator by iFtw this cycle.
REQ-006 iFtw  input  24  frequency tuning word; unsigned, one full cycle = 2^24.
REQ-007 iLoad  input  1  load accumulator with iPhase this cycle.
REQ-008 iPhase  input  24  phase load value.
REQ-009 oCx_g  output  14  first-quadrant folded phase; drives the cosine stage iCx_g.
REQ-010 oQuad  output  2  quadrant of the sample on oCx_g.
REQ-011 oNeg  output  1  cosine sign for the sample on oCx_g (1 = negate).
REQ-012 oNegAlign  output  1  oNeg delayed one cycle; aligned with the 1-cycle cosine LUT output.
REQ-013 oValid  output  1  oCx_g/oQuad/oNeg hold a new sample.
REQ-014 oValidAlign  output  1  oValid delayed one cycle; aligned with oNegAlign.

Function
REQ-015 Stage 1: rAcc SHALL update at each edge: iLoad=1 -> iPhase; else iEn=1 -> rAcc+iFtw mod 2^24; else hold.
REQ-016 iLoad and iEn both high: load wins, no increment that cycle.
REQ-017 Stage 1 valid rV1 SHALL register (iEn | iLoad).
REQ-018 Phase word p = rAcc (dither disabled) or rAcc + dither (REQ-030), mod 2^24; q = p[23:22], f = p[21:8].
REQ-019 Fold: q=0 -> x=f, neg=0; q=1 -> x=~f, neg=1; q=2 -> x=f, neg=1; q=3 -> x=~f, neg=0 (~ = bitwise complement, 14 bits).
REQ-020 Stage 2 SHALL register x->oCx_g, q->oQuad, neg->oNeg, rV1->oValid every cycle, regardless of enables.
REQ-021 oNegAlign and oValidAlign SHALL register oNeg and oValid every cycle.
REQ-022 Latency: iEn/iLoad at edge n -> oCx_g/oValid at edge n+1 -> oNegAlign/oValidAlign at edge n+2.
REQ-023 Accumulator wrap-around SHALL be silent modular; no overflow flag.
REQ-024 iFtw = 0 with iEn=1: oValid stays high, oCx_g constant.
REQ-025 iFtw/iPhase sampled only on the enabling edge; changes while iEn=iLoad=0 have no effect.
REQ-026 Boundary phases: p=0x000000 -> oCx_g=0x0000, q=0; p=0x3FFFFF -> oCx_g=0x3FFF, q=0; p=0x400000 -> oCx_g=0x3FFF, q=1, neg=1.

Reset
REQ-027 iRst high SHALL immediately clear rAcc, rV1, oCx_g, oQuad, oNeg, oNegAlign, oValid, oValidAlign to 0.
REQ-028 Reset asserted mid-stream SHALL drop all in-flight samples; no valid output until two edges after first post-reset iEn/iLoad.
REQ-029 With dither compiled in, reset SHALL set the LFSR to 16'hACE1.

Configuration
REQ-030 Macro PHASE_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing on each edge with rV1=1; dither = {16'b0, lfsr[7:0]} added to rAcc before fold.
REQ-031 PHASE_DITHER_EN undefined: no LFSR; p = rAcc (plain truncation of bits [7:0]); all other behaviour identical.

Verification
REQ-032 Reset, iLoad=1 iPhase=0, then iEn=1 iFtw=0x400000 x4 (dither off) -> oQuad 0,1,2,3; oCx_g 0x0000,0x3FFF,0x0000,0x3FFF; oNeg 0,1,1,0.
REQ-033 iLoad=1 with iEn=1, iPhase=0x123456, iFtw=0x000100 -> next oCx_g = 0x1234 (q=0, f=0x1234), no increment applied.
REQ-034 Load 0xFFFF00, iEn=1 iFtw=0x000200 -> wrap to 0x000100; oQuad 0, oCx_g 0x0001, oNeg 0.
REQ-035 Single iEn pulse -> oValid high exactly one cycle at n+1, oValidAlign exactly one cycle at n+2, oNegAlign equals prior oNeg.
REQ-036 Assert iRst mid-stream with oValid high -> all outputs 0 asynchronously before next edge; resume matches REQ-028.
REQ-037 PHASE_DITHER_EN build, iFtw=0, rAcc=0x000000, iEn=1 -> first LFSR dither = 0xE1 added, oCx_g stays 0x0000; LFSR sequence matches reference model over 1000 cycles.
